instr_mem_fetch_nw: RTL
=======================

Name: instr_mem_fetch_nw

Overview:
- Parametrised multi-lane instruction memory for the superscalar core. Replaces the fixed two-port combinational ROM.
- Delivers LANES consecutive instruction words per fetch: lane k reads pc+4k.
- Read is registered, with per-lane valid bits.
- A reset-time INIT sequencer fills every word with NOP; a load port writes the program at run time.
- Sits between the PC/fetch unit and the decode/issue stage.

Parameters:
LANES, 2, instruction words fetched per request (1..8)
DEPTH, 256, memory size in 32-bit words (power of two)
BASE_ADDR, 32'h00400000, byte address of word 0
NOP_WORD, 32'h38000000, INIT fill value
BAD_WORD, 32'hFFFFFFFF, data returned for an out-of-range lane

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous reset, active-low
rd_n  in  1  fetch enable, active-low (memory enabled with 0)
stall  in  1  1 = hold fetch outputs, no new read
pc  in  32  byte address of lane 0
instr  out  32*LANES  lane k at bits [32k+31:32k]
instr_valid  out  LANES  per-lane valid
fault  out  1  misaligned pc on the last accepted fetch
busy  out  1  INIT in progress
ld_we  in  1  load-port write strobe
ld_addr  in  32  load byte address
ld_data  in  32  load data
ld_ack  out  1  one-cycle pulse, write performed

Behaviour:
- Reset (rst_n=0, asynchronous), output values: instr=0, instr_valid=0, fault=0, ld_ack=0, busy=1; FSM enters INIT with init counter 0.
- FSM INIT:
  - Each cycle writes NOP_WORD to word[cnt], then cnt++.
  - After word DEPTH-1 is written, FSM goes to RUN and busy falls. INIT lasts exactly DEPTH cycles after rst_n deasserts.
  - In INIT, fetch and ld_we are ignored; instr and instr_valid stay 0.
- Address decode:
  - idx = (addr - BASE_ADDR) >> 2.
  - In range iff addr >= BASE_ADDR, idx < DEPTH and addr[1:0]==0.
  - pc+4k is computed modulo 2^32; a wrapped address is out of range.
- Fetch (RUN):
  - Accepted when rd_n=0 and stall=0. Results register on the same edge and are visible the next cycle (latency 1).
  - For each lane k: if pc+4k is in range, instr_k=word[idx] and valid_k=1; otherwise instr_k=BAD_WORD and valid_k=0.
  - Misaligned pc (pc[1:0]!=0): all lanes get BAD_WORD, all valid=0, and fault=1. Any aligned accepted fetch clears fault.
- rd_n=1 and stall=0 (RUN): instr=0, instr_valid=0, fault=0 on the next edge.
- stall=1: instr, instr_valid and fault hold their values regardless of rd_n and pc.
- Load port (RUN only):
  - ld_we=1 with an in-range, aligned ld_addr writes word[idx]; ld_ack=1 next cycle.
  - ld_we=1 with an out-of-range or misaligned ld_addr: no write, ld_ack=0.
  - ld_we=0: ld_ack=0. ld_ack is never asserted two cycles for a single strobe.
- Write and fetch to the same word in the same cycle: the fetch returns the old data (read-before-write). The new data is seen from the next fetch on.
- Two lanes may hit the same word only through wrap; each lane decodes independently.
- Reset asserted mid-INIT or mid-RUN: immediate return to reset values and INIT restarts from cnt=0. Memory contents are overwritten to NOP by INIT.
- No combinational path from any input to any output; all outputs are registered.

Test Plan:
- Reset, INIT length, fill: release rst_n and count cycles.
  - busy stays 1 for exactly 256 cycles, then 0.
  - A fetch at pc=32'h00400000 returns instr=64'h38000000_38000000 with valid=2'b11.
- Load then fetch:
  - Write 32'h8D710000 to 0x00400008 and 32'h8D720004 to 0x0040000C; each write gives an ld_ack pulse.
  - Fetch pc=0x00400008 → lane0=32'h8D710000, lane1=32'h8D720004, valid=2'b11, one cycle later.
- Upper boundary: fetch pc=0x004003FC (last word) → lane0 valid with its data; lane1 = 32'hFFFFFFFF, valid=2'b01.
- Misalignment and out-of-range load:
  - Fetch pc=0x00400002 → valid=0, both lanes 32'hFFFFFFFF, fault=1.
  - Next fetch pc=0x00400000 → fault=0.
  - ld_we to 0x00000000 → ld_ack stays 0 and memory is unchanged.
- Stall, disable, collision:
  - stall=1 while pc changes → outputs are frozen.
  - rd_n=1 → instr=0, valid=0.
  - Simultaneous write 32'h12345678 and fetch at 0x00400010 → old value returned; the next fetch returns 32'h12345678.
- Reset mid-operation: assert rst_n=0 during INIT at cnt=100 and also during a stalled RUN fetch → outputs zero immediately and INIT reruns for the full 256 cycles.

Source files
------------

// File: rtl/instr_mem_fetch_nw_if.sv
// Fetch/load bus between the PC/fetch unit and the multi-lane instruction memory.
interface instr_mem_fetch_nw_if #(
    parameter int unsigned LANES = 2
);
    logic                  rd_n;
    logic                  stall;
    logic [31:0]           pc;
    logic [32*LANES-1:0]   instr;
    logic [LANES-1:0]      instr_valid;
    logic                  fault;
    logic                  busy;
    logic                  ld_we;
    logic [31:0]           ld_addr;
    logic [31:0]           ld_data;
    logic                  ld_ack;

    modport master (
        output rd_n, stall, pc, ld_we, ld_addr, ld_data,
        input  instr, instr_valid, fault, busy, ld_ack
    );

    modport slave (
        input  rd_n, stall, pc, ld_we, ld_addr, ld_data,
        output instr, instr_valid, fault, busy, ld_ack
    );
endinterface

// File: rtl/instr_mem_fetch_nw.sv
// Multi-lane instruction memory: LANES consecutive words per fetch, registered read,
// NOP fill sequencer after reset and a run-time program load port.
module instr_mem_fetch_nw #(
    parameter int unsigned LANES     = 2,
    parameter int unsigned DEPTH     = 256,
    parameter logic [31:0] BASE_ADDR = 32'h0040_0000,
    parameter logic [31:0] NOP_WORD  = 32'h3800_0000,
    parameter logic [31:0] BAD_WORD  = 32'hFFFF_FFFF
) (
    input  logic                 clk,
    input  logic                 rst_n,
    instr_mem_fetch_nw_if.slave  bus
);
    localparam int unsigned IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned IW    = 32 * LANES;

    typedef enum logic {ST_INIT, ST_RUN} state_t;

    state_t               state, state_next;
    logic [IDX_W-1:0]     cnt, cnt_next;

    logic [31:0]          mem [DEPTH];
    logic                 mem_we;
    logic [IDX_W-1:0]     mem_wa;
    logic [31:0]          mem_wd;

    logic [IW-1:0]        instr_q, instr_next;
    logic [LANES-1:0]     valid_q, valid_next;
    logic                 fault_q, fault_next;
    logic                 busy_q, busy_next;
    logic                 ack_q, ack_next;

    logic [32:0]          lane_addr [LANES];
    logic [IDX_W-1:0]     lane_idx  [LANES];
    logic [LANES-1:0]     lane_ok;
    logic [IW-1:0]        lane_data;
    logic                 ld_ok;
    logic [IDX_W-1:0]     ld_idx;

    // In range: not wrapped past 2^32, at/above base, word aligned, inside DEPTH words.
    function automatic logic addr_ok(input logic [32:0] a);
        logic [31:0] off;
        off = a[31:0] - BASE_ADDR;
        return !a[32] && (a[31:0] >= BASE_ADDR) && (a[1:0] == 2'b00)
               && ((off >> 2) < 32'(DEPTH));
    endfunction

    function automatic logic [IDX_W-1:0] idx_of(input logic [31:0] a);
        logic [31:0] off;
        off = a - BASE_ADDR;
        return IDX_W'(off >> 2);
    endfunction

    // Per-lane decode; each lane checks its own address independently.
    always_comb begin
        lane_data = '0;
        lane_ok   = '0;
        for (int k = 0; k < int'(LANES); k++) begin
            lane_addr[k] = {1'b0, bus.pc} + 33'(4 * k);
            lane_idx[k]  = idx_of(lane_addr[k][31:0]);
            lane_ok[k]   = addr_ok(lane_addr[k]);
            lane_data[32*k +: 32] = lane_ok[k] ? mem[lane_idx[k]] : BAD_WORD;
        end
        ld_ok  = addr_ok({1'b0, bus.ld_addr});
        ld_idx = idx_of(bus.ld_addr);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= ST_INIT;
            cnt     <= '0;
            instr_q <= '0;
            valid_q <= '0;
            fault_q <= 1'b0;
            busy_q  <= 1'b1;
            ack_q   <= 1'b0;
        end else begin
            state   <= state_next;
            cnt     <= cnt_next;
            instr_q <= instr_next;
            valid_q <= valid_next;
            fault_q <= fault_next;
            busy_q  <= busy_next;
            ack_q   <= ack_next;
        end
    end

    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        mem_we     = 1'b0;
        mem_wa     = ld_idx;
        mem_wd     = bus.ld_data;
        ack_next   = 1'b0;
        instr_next = instr_q;
        valid_next = valid_q;
        fault_next = fault_q;

        case (state)
            ST_INIT: begin
                mem_we   = 1'b1;
                mem_wa   = cnt;
                mem_wd   = NOP_WORD;
                cnt_next = cnt + IDX_W'(1);
                if (cnt == IDX_W'(DEPTH - 1)) begin
                    state_next = ST_RUN;
                    cnt_next   = '0;
                end
            end
            ST_RUN: begin
                if (bus.ld_we && ld_ok) begin
                    mem_we   = 1'b1;
                    ack_next = 1'b1;
                end
                if (!bus.stall) begin
                    if (!bus.rd_n) begin
                        instr_next = lane_data;
                        valid_next = lane_ok;
                        fault_next = (bus.pc[1:0] != 2'b00);
                    end else begin
                        instr_next = '0;
                        valid_next = '0;
                        fault_next = 1'b0;
                    end
                end
            end
            default: state_next = ST_INIT;
        endcase

        busy_next = (state_next == ST_INIT);
    end

    // Storage has no reset; the INIT sweep provides the known contents.
    always_ff @(posedge clk) begin
        if (mem_we) mem[mem_wa] <= mem_wd;
    end

    assign bus.instr       = instr_q;
    assign bus.instr_valid = valid_q;
    assign bus.fault       = fault_q;
    assign bus.busy        = busy_q;
    assign bus.ld_ack      = ack_q;
endmodule
